instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 167 ++++++++++++++++
 tb/tb_instr_encoder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// RV32I field-bundle to machine-word encoder with valid/ready handshake.
// Optional immediate range checking is enabled by defining ENC_IMM_CHECK_EN.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_class,
  input  logic [2:0]  in_funct3,
  input  logic        in_f7b5,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STOR = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUI  = 7'b0010111;

  state_e      state_q, state_d;
  logic        vld_q, vld_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] addr_q, addr_d;
  logic        err_q, err_d;

  logic        accept;
  logic        xfer;
  logic        illegal;
  logic        cls_bad;
  logic        imm_bad;
  logic        is_shift;
  logic [31:0] word;

  assign in_ready  = (state_q == RUN) && (!vld_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign xfer      = vld_q && out_ready;
  assign out_valid = vld_q;
  assign out_instr = instr_q;
  assign out_addr  = addr_q;
  assign err       = err_q;

  assign cls_bad  = in_class > 4'd8;
  assign is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);

  // Pack the current bundle into an RV32I word.
  always_comb begin
    word = 32'h0;
    case (in_class)
      4'd0: word = {1'b0, in_f7b5, 5'b0, in_rs2, in_rs1,
                    in_funct3, in_rd, OP_R};
      4'd1: begin
        if (is_shift)
          word = {1'b0, in_f7b5, 5'b0, in_imm[4:0], in_rs1,
                  in_funct3, in_rd, OP_IALU};
        else
          word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_IALU};
      end
      4'd2: word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
      4'd3: word = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:0], OP_STOR};
      4'd4: word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1,
                    in_funct3, in_imm[4:1], in_imm[11], OP_BR};
      4'd5: word = {in_imm[20], in_imm[10:1], in_imm[11],
                    in_imm[19:12], in_rd, OP_JAL};
      4'd6: word = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_JALR};
      4'd7: word = {in_imm[31:12], in_rd, OP_LUI};
      4'd8: word = {in_imm[31:12], in_rd, OP_AUI};
      default: word = 32'h0;
    endcase
  end

`ifdef ENC_IMM_CHECK_EN
  logic s12_ok;
  logic s13_ok;
  logic s21_ok;

  assign s12_ok = (&in_imm[31:11]) || !(|in_imm[31:11]);
  assign s13_ok = ((&in_imm[31:12]) || !(|in_imm[31:12]))
                  && !in_imm[0];
  assign s21_ok = ((&in_imm[31:20]) || !(|in_imm[31:20]))
                  && !in_imm[0];

  // Flag immediates that do not fit the target field.
  always_comb begin
    imm_bad = 1'b0;
    case (in_class)
      4'd1: imm_bad = is_shift ? (|in_imm[31:5]) : !s12_ok;
      4'd2,
      4'd3,
      4'd6: imm_bad = !s12_ok;
      4'd4: imm_bad = !s13_ok;
      4'd5: imm_bad = !s21_ok;
      4'd7,
      4'd8: imm_bad = |in_imm[11:0];
      default: imm_bad = 1'b0;
    endcase
  end
`else
  assign imm_bad = 1'b0;
`endif

  assign illegal = cls_bad || imm_bad;

  // Next-state: handshake, address advance, halt/clear control.
  always_comb begin
    state_d = state_q;
    vld_d   = vld_q;
    instr_d = instr_q;
    addr_d  = addr_q;
    err_d   = err_q;
    if (xfer) begin
      vld_d  = 1'b0;
      addr_d = addr_q + 32'd4;
    end
    if (accept) begin
      if (illegal) begin
        err_d   = 1'b1;
        state_d = HALT;
      end else begin
        vld_d   = 1'b1;
        instr_d = word;
      end
    end
    if (clr && state_q == HALT) begin
      err_d   = 1'b0;
      state_d = RUN;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      vld_q   <= 1'b0;
      instr_q <= 32'h0;
      addr_q  <= BASE_ADDR;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder.
// Expected words are hand-encoded RV32I values.
module tb_instr_encoder;

  logic        clk;
  logic        rst;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_class;
  logic [2:0]  in_funct3;
  logic        in_f7b5;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err;

  int n_cmp;
  int n_bad;

  instr_encoder #(.BASE_ADDR(32'h0000_0000)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_class  (in_class),
    .in_funct3 (in_funct3),
    .in_f7b5   (in_f7b5),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] c, input logic [2:0] f3,
                       input logic f7, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm);
    in_valid  = 1'b1;
    in_class  = c;
    in_funct3 = f3;
    in_f7b5   = f7;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_imm    = imm;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    clr = 1'b0;
    in_valid = 1'b0;
    in_class = '0;
    in_funct3 = '0;
    in_f7b5 = 1'b0;
    in_rd = '0;
    in_rs1 = '0;
    in_rs2 = '0;
    in_imm = '0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_addr", out_addr, 32'h0);
    chk("rst_err", {31'b0, err}, 32'd0);
    rst = 1'b0;
    chk("rst_ready", {31'b0, in_ready}, 32'd1);

    // ADDI x1, x0, 5
    drive(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    tick();
    in_valid = 1'b0;
    chk("addi_valid", {31'b0, out_valid}, 32'd1);
    chk("addi_instr", out_instr, 32'h00500093);
    chk("addi_addr", out_addr, 32'h0);
    tick();
    chk("addi_drain", {31'b0, out_valid}, 32'd0);
    chk("addi_next", out_addr, 32'h4);

    // back-to-back R / STORE / BRANCH from a fresh base
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(4'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
    tick();
    chk("add_instr", out_instr, 32'h002081B3);
    chk("add_addr", out_addr, 32'h0);
    drive(4'd3, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);
    tick();
    chk("sw_instr", out_instr, 32'h0020A423);
    chk("sw_addr", out_addr, 32'h4);
    drive(4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);
    tick();
    in_valid = 1'b0;
    chk("beq_instr", out_instr, 32'h00208463);
    chk("beq_addr", out_addr, 32'h8);
    chk("beq_valid", {31'b0, out_valid}, 32'd1);
    tick();
    chk("b2b_drain", {31'b0, out_valid}, 32'd0);
    chk("b2b_addr", out_addr, 32'hC);

    // JAL held under backpressure, then LUI
    out_ready = 1'b0;
    drive(4'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd16);
    tick();
    drive(4'd7, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000);
    for (int i = 0; i < 3; i++) begin
      chk("jal_instr", out_instr, 32'h010000EF);
      chk("jal_addr", out_addr, 32'hC);
      chk("jal_stall", {31'b0, in_ready}, 32'd0);
      if (i < 2) tick();
    end
    out_ready = 1'b1;
    #1;
    chk("lui_ready", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("lui_instr", out_instr, 32'h123452B7);
    chk("lui_addr", out_addr, 32'h10);
    tick();
    chk("lui_next", out_addr, 32'h14);

    // illegal class -> halt until clr
    drive(4'd12, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    tick();
    chk("ill_err", {31'b0, err}, 32'd1);
    chk("ill_valid", {31'b0, out_valid}, 32'd0);
    chk("ill_ready", {31'b0, in_ready}, 32'd0);
    drive(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    tick();
    chk("halt_novalid", {31'b0, out_valid}, 32'd0);
    chk("halt_ready", {31'b0, in_ready}, 32'd0);
    in_valid = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_err", {31'b0, err}, 32'd0);
    chk("clr_ready", {31'b0, in_ready}, 32'd1);
    drive(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    tick();
    chk("post_instr", out_instr, 32'h00500093);
    chk("post_addr", out_addr, 32'h14);

    // SRAI x2, x3, 4 accepted in the same cycle as a transfer
    drive(4'd1, 3'd5, 1'b1, 5'd2, 5'd3, 5'd0, 32'd4);
    tick();
    in_valid = 1'b0;
    chk("srai_instr", out_instr, 32'h4041D113);
    chk("srai_addr", out_addr, 32'h18);
    tick();

    // misaligned branch offset
    drive(4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3);
    tick();
    in_valid = 1'b0;
`ifdef ENC_IMM_CHECK_EN
    chk("bimm_err", {31'b0, err}, 32'd1);
    chk("bimm_valid", {31'b0, out_valid}, 32'd0);
    chk("bimm_addr", out_addr, 32'h1C);
`else
    chk("bimm_err", {31'b0, err}, 32'd0);
    chk("bimm_instr", out_instr, 32'h00208163);
    chk("bimm_addr", out_addr, 32'h1C);
`endif
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr2_err", {31'b0, err}, 32'd0);
    chk("clr2_ready", {31'b0, in_ready}, 32'd1);
`ifdef ENC_IMM_CHECK_EN
    chk("clr2_addr", out_addr, 32'h1C);
`else
    chk("clr2_addr", out_addr, 32'h20);
`endif

    // AUIPC (highest legal class) then class 9
    drive(4'd8, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h00001000);
    tick();
    chk("auipc_instr", out_instr, 32'h00001097);
    drive(4'd9, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0);
    tick();
    in_valid = 1'b0;
    chk("cls9_err", {31'b0, err}, 32'd1);
    chk("cls9_valid", {31'b0, out_valid}, 32'd0);

    // reset discards a stalled word and overrides HALT
    clr = 1'b1;
    tick();
    clr = 1'b0;
    out_ready = 1'b0;
    drive(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    tick();
    in_valid = 1'b0;
    chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_valid", {31'b0, out_valid}, 32'd0);
    chk("rst2_addr", out_addr, 32'h0);
    chk("rst2_instr", out_instr, 32'h0);
    out_ready = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
